perceptron_train_ctrl: RTL

- Training sequencer for the 7-input perceptron datapath.
- Holds a small sample store of 7-bit input vectors plus a 1-bit label, written by the host.
- On start, presents samples to the perceptron one per slot, drives exp_res and threshold, and compares the returned result with the label.
- Runs whole epochs until an error-free epoch (converged) or until max_epochs is reached, then reports status.

---
 rtl/perceptron_pkg.sv | 23 ++
 rtl/pcpt_sample_mem.sv | 32 +++
 rtl/perceptron_train_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron training sequencer: state codes,
// result encodings and the label-to-result mapping.
package perceptron_pkg;

    localparam int PCPT_LATENCY_DEF = 2;

    localparam logic [1:0] RES_POS = 2'b01;
    localparam logic [1:0] RES_NEG = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD      = 3'd1;
    localparam state_t ST_PRESENT   = 3'd2;
    localparam state_t ST_CHECK     = 3'd3;
    localparam state_t ST_EPOCH_END = 3'd4;
    localparam state_t ST_FINISH    = 3'd5;

    function automatic logic [1:0] label_to_res(input logic label);
        return label ? RES_POS : RES_NEG;
    endfunction

endpackage

// File: rtl/pcpt_sample_mem.sv
// Sample store: synchronous write, asynchronous read, synchronous clear on
// active-low reset. Entry format is {label, vector[6:0]}.
module pcpt_sample_mem #(
    parameter int NUM_SAMPLES = 8,
    parameter int ADDR_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [NUM_SAMPLES];

    // NOTE: the store is a register file, so clearing every entry on reset is
    // cheap and makes a fresh run deterministic; a RAM macro would not allow it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training sequencer for the 7-input perceptron: presents stored samples epoch
// by epoch until an error-free epoch or the epoch limit. Option: PCPT_ROTATE_ORDER_EN.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int NUM_SAMPLES  = 8,
    parameter int ADDR_W       = 3,
    parameter int PCPT_LATENCY = PCPT_LATENCY_DEF,
    parameter int EPOCH_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic [ADDR_W:0]    sample_count,
    input  logic [7:0]         threshold_in,
    input  logic [EPOCH_W-1:0] max_epochs,
    input  logic               start,
    output logic [6:0]         pcpt_in,
    output logic [7:0]         pcpt_threshold,
    output logic               pcpt_exp_res,
    input  logic [1:0]         pcpt_result,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic [ADDR_W:0]    error_count
);

    localparam int LAT_W = $clog2(PCPT_LATENCY + 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [7:0]         thr_q, thr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [EPOCH_W-1:0] max_q, max_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [ADDR_W:0]    err_q, err_d;
    logic               conv_q, conv_d;
    logic [6:0]         pcpt_in_q;
    logic               exp_q;
    logic [7:0]         rd_data;
    logic [ADDR_W:0]    last_pos;
    logic [ADDR_W-1:0]  idx_next;
`ifdef PCPT_ROTATE_ORDER_EN
    logic [ADDR_W-1:0]  start_idx_q, start_idx_d;
`endif

    pcpt_sample_mem #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (cfg_wr && (state_q == ST_IDLE)),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_addr_i (idx_d),
        .rd_data_o (rd_data)
    );

    // Index arithmetic wraps at the latched sample count, not at NUM_SAMPLES.
    assign last_pos = count_q - (ADDR_W + 1)'(1);
    assign idx_next = ({1'b0, idx_q} == last_pos) ? '0 : idx_q + ADDR_W'(1);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        thr_d   = thr_q;
        count_d = count_q;
        max_d   = max_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        conv_d  = conv_q;
`ifdef PCPT_ROTATE_ORDER_EN
        start_idx_d = start_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    thr_d   = threshold_in;
                    count_d = sample_count;
                    max_d   = max_epochs;
                end
            end
            ST_LOAD: begin
                epoch_d = '0;
                err_d   = '0;
                conv_d  = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
                lat_d   = '0;
`ifdef PCPT_ROTATE_ORDER_EN
                start_idx_d = '0;
`endif
                if (count_q == '0 || count_q > (ADDR_W + 1)'(NUM_SAMPLES) || max_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (lat_q == LAT_W'(PCPT_LATENCY - 1)) begin
                    lat_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_CHECK: begin
                if (pcpt_result != label_to_res(exp_q) && err_q != '1) begin
                    err_d = err_q + (ADDR_W + 1)'(1);
                end
                if ({1'b0, cnt_q} == last_pos) begin
                    state_d = ST_EPOCH_END;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    idx_d   = idx_next;
                    state_d = ST_PRESENT;
                end
            end
            ST_EPOCH_END: begin
                if (epoch_q != '1) begin
                    epoch_d = epoch_q + EPOCH_W'(1);
                end
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (({1'b0, epoch_q} + (EPOCH_W + 1)'(1)) == {1'b0, max_q}) begin
                    state_d = ST_FINISH;
                end else begin
                    err_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_PRESENT;
`ifdef PCPT_ROTATE_ORDER_EN
                    start_idx_d = ({1'b0, start_idx_q} == last_pos) ? '0 : start_idx_q + ADDR_W'(1);
                    idx_d       = start_idx_d;
`else
                    idx_d       = '0;
`endif
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            thr_q     <= '0;
            count_q   <= '0;
            max_q     <= '0;
            epoch_q   <= '0;
            err_q     <= '0;
            conv_q    <= 1'b0;
            pcpt_in_q <= '0;
            exp_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            thr_q   <= thr_d;
            count_q <= count_d;
            max_q   <= max_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            // Sample is captured on entry to PRESENT and held through CHECK.
            if (state_d == ST_PRESENT && state_q != ST_PRESENT) begin
                pcpt_in_q <= rd_data[6:0];
                exp_q     <= rd_data[7];
            end
        end
    end

`ifdef PCPT_ROTATE_ORDER_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_idx_q <= '0;
        end else begin
            start_idx_q <= start_idx_d;
        end
    end
`endif

    assign pcpt_in        = pcpt_in_q;
    assign pcpt_exp_res   = exp_q;
    assign pcpt_threshold = thr_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_PRESENT) ||
                            (state_q == ST_CHECK) || (state_q == ST_EPOCH_END);
    assign done           = (state_q == ST_FINISH);
    assign converged      = conv_q;
    assign epoch_count    = epoch_q;
    assign error_count    = err_q;

endmodule
